// File: rtl/hazard_stall_ctrl.sv
// Purpose: decode-stage pipeline control; per-stage enables, IF/ID flush, ID/EX bubble, HALT drain.
// Latency: enables/flush/bubble are combinational (same-edge effect); state and drain counter are registered.
// Backpressure: mem_busy freezes every stage and holds all state. Optional stall counter: HAZARD_STALL_CNT_EN.
module hazard_stall_ctrl #(
  parameter int REG_W        = 3,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_halt,
  input  logic             ex_is_load,
  input  logic             ex_wr_en,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES);

  state_e     state_q, state_d, cur_state;
  logic [3:0] drain_q, drain_d;
  logic       load_use;

  // Load-use: the EX load's destination is a register ID actually reads (R0 included).
  always_comb begin
    load_use = id_valid & ex_is_load & ex_wr_en &
               ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  end

  // Next-state and output decode; reset forces RUN behaviour for the reset cycle itself.
  always_comb begin
    cur_state   = rst ? ST_RUN : state_q;
    state_d     = cur_state;
    drain_d     = drain_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;

    case (cur_state)
      ST_RUN: begin
        if (mem_busy) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end else if (ex_redirect) begin
          // Squashes whatever sits in ID, including a hazarding or HALT instruction.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_valid && id_halt) begin
          // HALT moves on to EX; nothing younger follows it.
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          state_d    = ST_DRAIN;
          drain_d    = DRAIN_INIT;
        end
      end

      ST_DRAIN: begin
        if (mem_busy) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end else begin
          // Redirects and hazards are ignored: only bubbles enter while older work retires.
          pc_en       = 1'b0;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (drain_q <= 4'd1) begin
            state_d = ST_HALTED;
            drain_d = 4'd0;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end
      end

      ST_HALTED: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        halted   = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
        drain_d = 4'd0;
      end
    endcase
  end

  // State register and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      drain_q <= 4'd0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count frozen-fetch cycles outside HALTED, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((cur_state != ST_HALTED) && !pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, mem_busy freeze, redirect priority, HALT drain, reset.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
// Output vector order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, halted}.
module tb_hazard_stall_ctrl;

  localparam int REG_W = 3;
  localparam int CNT_W = 16;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  localparam logic [7:0] V_RUN    = 8'b11111_000;
  localparam logic [7:0] V_BUSY   = 8'b00000_000;
  localparam logic [7:0] V_REDIR  = 8'b11111_110;
  localparam logic [7:0] V_LU     = 8'b00111_010;
  localparam logic [7:0] V_HALTDT = 8'b01111_100;
  localparam logic [7:0] V_DRAIN  = 8'b01111_110;
  localparam logic [7:0] V_HALTED = 8'b00000_001;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt;
  logic             id_uses_rs, id_uses_rt, id_halt;
  logic             ex_is_load, ex_wr_en;
  logic [REG_W-1:0] ex_rd;
  logic             ex_redirect, mem_busy;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_bubble, halted;
  logic [CNT_W-1:0] stall_cycles;
  logic [7:0]       outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_halt      (id_halt),
    .ex_is_load   (ex_is_load),
    .ex_wr_en     (ex_wr_en),
    .ex_rd        (ex_rd),
    .ex_redirect  (ex_redirect),
    .mem_busy     (mem_busy),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and return all hazard inputs to idle.
  task automatic next_cycle();
    @(negedge clk);
    id_valid    = 1'b0;
    id_rs       = '0;
    id_rt       = '0;
    id_uses_rs  = 1'b0;
    id_uses_rt  = 1'b0;
    id_halt     = 1'b0;
    ex_is_load  = 1'b0;
    ex_wr_en    = 1'b0;
    ex_rd       = '0;
    ex_redirect = 1'b0;
    mem_busy    = 1'b0;
  endtask

  // Load to R3 in EX, ID reads R3 through rs.
  task automatic set_load_use();
    id_valid   = 1'b1;
    id_rs      = 3'd3;
    id_uses_rs = 1'b1;
    ex_is_load = 1'b1;
    ex_wr_en   = 1'b1;
    ex_rd      = 3'd3;
  endtask

  task automatic expect_outs(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, 32'(outs), 32'(exp));
  endtask

  task automatic expect_cnt(input string tag, input int unsigned n);
    chk(tag, 32'(stall_cycles), CNT_ON ? n : 32'd0);
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    expect_outs("reset_cycle_outs", V_RUN);
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    // ---- reset state ----
    next_cycle();
    expect_outs("reset_idle_outs", V_RUN);
    expect_cnt("reset_cnt", 0);
    next_cycle();
    rst = 1'b0;
    expect_outs("run_idle", V_RUN);
    expect_cnt("run_idle_cnt", 0);

    // ---- load-use variants ----
    next_cycle(); set_load_use();
    expect_outs("lu_rs_stall", V_LU);
    next_cycle(); id_valid = 1'b1; id_rs = 3'd3; id_uses_rs = 1'b1;
    expect_outs("lu_after_bubble", V_RUN);
    next_cycle(); set_load_use(); id_uses_rs = 1'b0;
    expect_outs("lu_rs_unused", V_RUN);
    next_cycle(); set_load_use(); id_rs = 3'd1; id_rt = 3'd3; id_uses_rt = 1'b1;
    expect_outs("lu_rt_stall", V_LU);
    next_cycle(); set_load_use(); ex_wr_en = 1'b0;
    expect_outs("lu_no_wr", V_RUN);
    next_cycle(); set_load_use(); id_valid = 1'b0;
    expect_outs("lu_id_invalid", V_RUN);
    next_cycle(); set_load_use(); id_rs = 3'd0; ex_rd = 3'd0;
    expect_outs("lu_r0", V_LU);
    next_cycle(); set_load_use(); ex_rd = 3'd4;
    expect_outs("lu_reg_differs", V_RUN);

    // ---- mem_busy over a load-use hazard, then the single bubble ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      next_cycle(); set_load_use(); mem_busy = 1'b1;
      expect_outs($sformatf("busy_freeze_%0d", i), V_BUSY);
    end
    next_cycle(); set_load_use();
    expect_outs("busy_then_lu", V_LU);
    next_cycle(); id_valid = 1'b1; id_rs = 3'd3; id_uses_rs = 1'b1;
    expect_outs("busy_lu_release", V_RUN);
    expect_cnt("busy_lu_cnt", 4);

    // ---- redirect outranks load-use and HALT ----
    next_cycle(); set_load_use(); id_halt = 1'b1; ex_redirect = 1'b1;
    expect_outs("redir_prio", V_REDIR);
    next_cycle();
    expect_outs("redir_stays_run", V_RUN);
    next_cycle(); ex_redirect = 1'b1; mem_busy = 1'b1;
    expect_outs("busy_redir_freeze", V_BUSY);
    next_cycle(); ex_redirect = 1'b1;
    expect_outs("redir_after_busy", V_REDIR);
    next_cycle(); id_halt = 1'b1;
    expect_outs("halt_not_valid", V_RUN);

    // ---- HALT drain with two busy cycles ----
    do_reset();
    next_cycle(); id_valid = 1'b1; id_halt = 1'b1;
    expect_outs("halt_detect", V_HALTDT);
    next_cycle();
    expect_outs("drain_1", V_DRAIN);
    next_cycle(); mem_busy = 1'b1;
    expect_outs("drain_busy_1", V_BUSY);
    next_cycle(); mem_busy = 1'b1;
    expect_outs("drain_busy_2", V_BUSY);
    next_cycle(); ex_redirect = 1'b1;
    expect_outs("drain_2_redir_ignored", V_DRAIN);
    next_cycle();
    expect_outs("drain_3", V_DRAIN);
    next_cycle();
    expect_outs("drain_4_last", V_DRAIN);
    next_cycle();
    expect_outs("halted_at_6", V_HALTED);
    expect_cnt("halt_cnt", 7);
    next_cycle(); set_load_use(); ex_redirect = 1'b1; mem_busy = 1'b1;
    expect_outs("halted_sticky", V_HALTED);
    next_cycle(); id_valid = 1'b1; id_halt = 1'b1;
    expect_outs("halted_sticky_2", V_HALTED);
    expect_cnt("halted_cnt_holds", 7);

    // ---- reset out of HALTED ----
    do_reset();
    expect_outs("post_reset_run", V_RUN);
    expect_cnt("post_reset_cnt", 0);
    next_cycle(); set_load_use();
    expect_outs("post_reset_lu", V_LU);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
